// File: rtl/lbuf_dp_ctrl_pkg.sv
// Shared types and constants for the dual-port local layer buffer.
// Defaults match the 208 x 128-bit per-layer buffers.
package lbuf_pkg;

  localparam int unsigned DATA_W_DEF = 128;
  localparam int unsigned DEPTH_DEF  = 208;
  localparam int unsigned ADDR_W_DEF = $clog2(DEPTH_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } lbuf_state_e;

  // Where a port's registered read data comes from.
  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_BYP  = 2'd1,
    SRC_ZERO = 2'd2
  } lbuf_rsrc_e;

  typedef struct packed {
    logic                  req;
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } lbuf_req_t;

  // Same-address collision kinds, named as <A op><B op>.
  localparam logic [2:0] COLL_NONE = 3'd0;
  localparam logic [2:0] COLL_RR   = 3'd1;
  localparam logic [2:0] COLL_WR   = 3'd2;
  localparam logic [2:0] COLL_RW   = 3'd3;
  localparam logic [2:0] COLL_WW   = 3'd4;

  // Kind of collision, given both ports request the same address.
  function automatic logic [2:0] lbuf_coll_kind(input logic a_we, input logic b_we);
    logic [2:0] kind;
    case ({a_we, b_we})
      2'b00:   kind = COLL_RR;
      2'b01:   kind = COLL_RW;
      2'b10:   kind = COLL_WR;
      default: kind = COLL_WW;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/lbuf_dp_ctrl_if.sv
// Request/ready bus for the two symmetric buffer ports.
// The master drives requests and the slave (the buffer) answers.
interface lbuf_dp_ctrl_if #(
  parameter int unsigned DATA_W = lbuf_pkg::DATA_W_DEF,
  parameter int unsigned ADDR_W = lbuf_pkg::ADDR_W_DEF
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ready;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ready;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata
  );
endinterface

// File: rtl/lbuf_dp_ctrl_mem.sv
// Behavioural true dual-port storage: synchronous write, registered read-first
// read with enable. Kept separate so it can be replaced by the SRAM macro.
module lbuf_mem #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 208,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_a_we,
  input  logic              i_a_re,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic [DATA_W-1:0] o_a_q,
  input  logic              i_b_we,
  input  logic              i_b_re,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic [DATA_W-1:0] o_b_q
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_a_q;
  logic [DATA_W-1:0] r_b_q;

  // The controller never lets both ports write the same word in one cycle.
  always_ff @(posedge i_clk) begin
    if (i_a_we) r_mem[i_a_addr] <= i_a_wdata;
    if (i_b_we) r_mem[i_b_addr] <= i_b_wdata;
    if (i_a_re) r_a_q <= r_mem[i_a_addr];
    if (i_b_re) r_b_q <= r_mem[i_b_addr];
  end

  assign o_a_q = r_a_q;
  assign o_b_q = r_b_q;

endmodule

// File: rtl/lbuf_dp_ctrl.sv
// Dual-port local layer buffer controller: zero-fill sweep FSM, port
// arbitration, write-first bypass for B, range check and sticky error flag.
module lbuf_dp_ctrl
  import lbuf_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned ADDR_W         = $clog2(DEPTH),
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic           CK,
  input  logic           RSTN,
  input  logic           clr_i,
  output logic           busy_o,
  input  logic           err_clr_i,
  output logic           err_o,
  lbuf_dp_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

  lbuf_state_e       r_state;
  logic [ADDR_W-1:0] r_cnt;

  logic              r_a_rvalid;
  logic              r_b_rvalid;
  lbuf_rsrc_e        r_a_src;
  lbuf_rsrc_e        r_b_src;
  logic [DATA_W-1:0] r_b_byp;
  logic              r_err;

  logic              w_idle;
  logic [2:0]        w_coll;
  logic              w_a_acc;
  logic              w_b_acc;
  logic              w_a_inr;
  logic              w_b_inr;
  logic              w_a_rd;
  logic              w_b_rd;
  logic              w_b_byp;
  logic              w_err_set;

  logic              w_ma_we;
  logic              w_ma_re;
  logic [ADDR_W-1:0] w_ma_addr;
  logic [DATA_W-1:0] w_ma_wdata;
  logic [DATA_W-1:0] w_ma_q;
  logic              w_mb_we;
  logic              w_mb_re;
  logic [DATA_W-1:0] w_mb_q;

  assign w_idle  = (r_state == IDLE);
  assign w_coll  = (bus.a_req && bus.b_req && (bus.a_addr == bus.b_addr))
                   ? lbuf_coll_kind(bus.a_we, bus.b_we) : COLL_NONE;

  assign bus.a_ready = w_idle;
  assign bus.b_ready = w_idle && (w_coll != COLL_WW);

  assign w_a_acc = bus.a_req && w_idle;
  assign w_b_acc = bus.b_req && w_idle && (w_coll != COLL_WW);
  assign w_a_inr = {1'b0, bus.a_addr} < LP_DEPTH;
  assign w_b_inr = {1'b0, bus.b_addr} < LP_DEPTH;
  assign w_a_rd  = w_a_acc && !bus.a_we;
  assign w_b_rd  = w_b_acc && !bus.b_we;
  assign w_b_byp = w_b_rd && w_a_acc && (w_coll == COLL_WR) && w_a_inr;

  assign w_err_set = (w_a_acc && !w_a_inr) || (w_b_acc && !w_b_inr);

  // Port A of the array is shared with the sweep; no request is accepted then.
  assign w_ma_we    = (r_state == CLEAR) || (w_a_acc && bus.a_we && w_a_inr);
  assign w_ma_re    = w_a_rd && w_a_inr;
  assign w_ma_addr  = (r_state == CLEAR) ? r_cnt : bus.a_addr;
  assign w_ma_wdata = (r_state == CLEAR) ? '0 : bus.a_wdata;
  assign w_mb_we    = w_b_acc && bus.b_we && w_b_inr;
  assign w_mb_re    = w_b_rd && w_b_inr && !w_b_byp;

  lbuf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk     (CK),
    .i_a_we    (w_ma_we),
    .i_a_re    (w_ma_re),
    .i_a_addr  (w_ma_addr),
    .i_a_wdata (w_ma_wdata),
    .o_a_q     (w_ma_q),
    .i_b_we    (w_mb_we),
    .i_b_re    (w_mb_re),
    .i_b_addr  (bus.b_addr),
    .i_b_wdata (bus.b_wdata),
    .o_b_q     (w_mb_q)
  );

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (clr_i) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
          end
        end
        CLEAR: begin
          if (r_cnt == LP_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Source selects only move on an accepted read, so rdata holds between reads.
  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_src    <= SRC_ZERO;
      r_b_src    <= SRC_ZERO;
      r_b_byp    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_a_rvalid <= w_a_rd;
      r_b_rvalid <= w_b_rd;
      if (w_a_rd) r_a_src <= w_a_inr ? SRC_MEM : SRC_ZERO;
      if (w_b_rd) begin
        if (!w_b_inr)     r_b_src <= SRC_ZERO;
        else if (w_b_byp) r_b_src <= SRC_BYP;
        else              r_b_src <= SRC_MEM;
      end
      if (w_b_byp) r_b_byp <= bus.a_wdata;
      if (w_err_set)      r_err <= 1'b1;
      else if (err_clr_i) r_err <= 1'b0;
    end
  end

  assign bus.a_rvalid = r_a_rvalid;
  assign bus.b_rvalid = r_b_rvalid;
  assign bus.a_rdata  = (r_a_src == SRC_MEM) ? w_ma_q : '0;

  always_comb begin
    bus.b_rdata = '0;
    unique case (r_b_src)
      SRC_MEM: bus.b_rdata = w_mb_q;
      SRC_BYP: bus.b_rdata = r_b_byp;
      default: bus.b_rdata = '0;
    endcase
  end

  assign busy_o = (r_state == CLEAR);
  assign err_o  = r_err;

endmodule

// File: tb/tb_lbuf_dp_ctrl.sv
// Self-checking bench for lbuf_dp_ctrl: a per-cycle word-array model of the
// buffer compared on every falling edge, plus directed literal checks.
module tb_lbuf_dp_ctrl;
  import lbuf_pkg::*;

  localparam int DW    = 128;
  localparam int DEPTH = 208;
  localparam int AW    = 8;

  logic CK = 1'b0;
  logic RSTN;
  logic clr_i;
  logic err_clr_i;
  logic busy_o;
  logic err_o;

  lbuf_dp_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  lbuf_dp_ctrl #(
    .DATA_W         (DW),
    .DEPTH          (DEPTH),
    .ADDR_W         (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .CK        (CK),
    .RSTN      (RSTN),
    .clr_i     (clr_i),
    .busy_o    (busy_o),
    .err_clr_i (err_clr_i),
    .err_o     (err_o),
    .bus       (bus)
  );

  always #5 CK = ~CK;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_busy;
  int            m_cnt;
  logic          m_a_val, m_b_val, m_err;
  logic [DW-1:0] m_a_dat, m_b_dat;
  int            coll_seen [5];

  initial for (int k = 0; k < 5; k++) coll_seen[k] = 0;

  always @(posedge CK or negedge RSTN) begin : model
    lbuf_req_t ra, rb;
    bit a_acc, b_acc, a_ok, b_ok, same;
    if (!RSTN) begin
      m_busy  <= 1'b1;
      m_cnt   <= 0;
      m_a_val <= 1'b0;
      m_b_val <= 1'b0;
      m_a_dat <= '0;
      m_b_dat <= '0;
      m_err   <= 1'b0;
    end else begin
      ra = '{bus.a_req, bus.a_we, bus.a_addr, bus.a_wdata};
      rb = '{bus.b_req, bus.b_we, bus.b_addr, bus.b_wdata};
      same  = ra.req && rb.req && (ra.addr == rb.addr);
      a_acc = ra.req && !m_busy;
      b_acc = rb.req && !m_busy && !(same && ra.we && rb.we);
      a_ok  = int'(ra.addr) < DEPTH;
      b_ok  = int'(rb.addr) < DEPTH;
      if (same && !m_busy) begin
        if (!ra.we && !rb.we)     coll_seen[COLL_RR]++;
        else if (ra.we && !rb.we) coll_seen[COLL_WR]++;
        else if (!ra.we && rb.we) coll_seen[COLL_RW]++;
        else                      coll_seen[COLL_WW]++;
      end
      m_a_val <= a_acc && !ra.we;
      m_b_val <= b_acc && !rb.we;
      if (a_acc && !ra.we) m_a_dat <= a_ok ? m_mem[ra.addr] : '0;
      if (b_acc && !rb.we)
        m_b_dat <= !b_ok ? '0 : ((a_acc && ra.we && same) ? ra.wdata : m_mem[rb.addr]);
      if (a_acc && ra.we && a_ok) m_mem[ra.addr] <= ra.wdata;
      if (b_acc && rb.we && b_ok) m_mem[rb.addr] <= rb.wdata;
      if ((a_acc && !a_ok) || (b_acc && !b_ok)) m_err <= 1'b1;
      else if (err_clr_i)                       m_err <= 1'b0;
      if (m_busy) begin
        m_mem[m_cnt] <= '0;
        if (m_cnt == DEPTH - 1) begin
          m_busy <= 1'b0;
          m_cnt  <= 0;
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end else if (clr_i) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end
    end
  end

  always @(negedge CK) begin
    if (chk_en) begin
      chk("busy_o",   DW'(busy_o),       DW'(m_busy));
      chk("a_ready",  DW'(bus.a_ready),  DW'(!m_busy));
      chk("b_ready",  DW'(bus.b_ready),  DW'(!m_busy && !(bus.a_req && bus.b_req && bus.a_we
                                              && bus.b_we && bus.a_addr == bus.b_addr)));
      chk("a_rvalid", DW'(bus.a_rvalid), DW'(m_a_val));
      chk("b_rvalid", DW'(bus.b_rvalid), DW'(m_b_val));
      chk("a_rdata",  bus.a_rdata,       m_a_dat);
      chk("b_rdata",  bus.b_rdata,       m_b_dat);
      chk("err_o",    DW'(err_o),        DW'(m_err));
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [DW-1:0] D11 = {16{8'h11}};
  localparam logic [DW-1:0] DAA = {16{8'hAA}};
  localparam logic [DW-1:0] D55 = {16{8'h55}};

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic idle_ports();
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    clr_i = 1'b0; err_clr_i = 1'b0;
  endtask

  task automatic set_a(input logic we, input int addr, input logic [DW-1:0] d);
    bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = AW'(addr); bus.a_wdata = d;
  endtask

  task automatic set_b(input logic we, input int addr, input logic [DW-1:0] d);
    bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = AW'(addr); bus.b_wdata = d;
  endtask

  // Counts falling edges with busy_o high; optionally re-pulses clr_i mid-sweep.
  task automatic count_busy(input string nm, input bit repulse);
    int n;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CK);
      clr_i = repulse && (n == 50);
      if (!busy_o) break;
      n++;
    end
    clr_i = 1'b0;
    chk(nm, DW'(n), DW'(DEPTH));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : stim
    idle_ports();
    RSTN = 1'b1;
    #1 RSTN = 1'b0;
    chk_en = 1'b1;
    @(negedge CK);
    chk("rst_busy",   DW'(busy_o),       DW'(1));
    chk("rst_rvalid", DW'(bus.a_rvalid), DW'(0));
    chk("rst_rdata",  bus.b_rdata,       '0);
    chk("rst_err",    DW'(err_o),        DW'(0));
    step();
    RSTN = 1'b1;
    count_busy("sweep_len", 1'b0);

    // First read after the sweep returns zero and rvalid pulses once
    set_a(1'b0, 5, '0); step(); idle_ports();
    @(negedge CK);
    chk("rd5_valid", DW'(bus.a_rvalid), DW'(1));
    chk("rd5_data",  bus.a_rdata,       '0);
    step();
    @(negedge CK);
    chk("rd5_pulse", DW'(bus.a_rvalid), DW'(0));

    // Write then read back
    set_a(1'b1, 7, D11); step();
    set_a(1'b0, 7, '0);  step(); idle_ports();
    @(negedge CK);
    chk("wr7_rd", bus.a_rdata, D11);

    // A write / B read same address, then A read / B write same address
    set_a(1'b1, 3, DAA); set_b(1'b0, 3, '0); step();
    set_a(1'b0, 3, '0);  set_b(1'b1, 3, D55);
    @(negedge CK);
    chk("byp_valid", DW'(bus.b_rvalid), DW'(1));
    chk("byp_data",  bus.b_rdata,       DAA);
    step(); idle_ports();
    @(negedge CK);
    chk("rdfirst", bus.a_rdata, DAA);
    set_a(1'b0, 3, '0); step(); idle_ports();
    @(negedge CK);
    chk("bwrite3", bus.a_rdata, D55);

    // Both write the same address: B stalls one cycle and wins
    set_a(1'b1, 9, DW'(1)); set_b(1'b1, 9, DW'(2));
    @(negedge CK);
    chk("ww_bstall", DW'(bus.b_ready), DW'(0));
    chk("ww_aready", DW'(bus.a_ready), DW'(1));
    step(); bus.a_req = 1'b0;
    @(negedge CK);
    chk("ww_bready", DW'(bus.b_ready), DW'(1));
    step(); idle_ports();
    set_a(1'b0, 9, '0); step(); idle_ports();
    @(negedge CK);
    chk("ww_final", bus.a_rdata, DW'(2));

    // Both read the same address
    set_a(1'b0, 7, '0); set_b(1'b0, 7, '0); step(); idle_ports();
    @(negedge CK);
    chk("rr_a", bus.a_rdata, D11);
    chk("rr_b", bus.b_rdata, D11);

    // Out-of-range accesses and the sticky error flag
    set_b(1'b0, 210, '0); step(); idle_ports();
    @(negedge CK);
    chk("oor_valid", DW'(bus.b_rvalid), DW'(1));
    chk("oor_data",  bus.b_rdata,       '0);
    chk("oor_err",   DW'(err_o),        DW'(1));
    set_a(1'b1, 250, '1); step(); idle_ports();
    set_a(1'b0, 42, '0); set_b(1'b0, 7, '0); step(); idle_ports();
    @(negedge CK);
    chk("oorw_42", bus.a_rdata, '0);
    chk("oorw_7",  bus.b_rdata, D11);
    err_clr_i = 1'b1; step(); idle_ports();
    @(negedge CK);
    chk("err_clr", DW'(err_o), DW'(0));
    err_clr_i = 1'b1; set_a(1'b0, 220, '0); step(); idle_ports();
    @(negedge CK);
    chk("err_setwins", DW'(err_o), DW'(1));
    err_clr_i = 1'b1; step(); idle_ports();

    // Read in the last idle cycle completes; reset mid-sweep restarts it
    set_a(1'b0, 9, '0); clr_i = 1'b1; step(); idle_ports();
    @(negedge CK);
    chk("clr_rvalid", DW'(bus.a_rvalid), DW'(1));
    chk("clr_rdata",  bus.a_rdata,       DW'(2));
    chk("clr_busy",   DW'(busy_o),       DW'(1));
    repeat (99) step();
    RSTN = 1'b0;
    step(); step();
    RSTN = 1'b1;
    count_busy("resweep_len", 1'b1);
    set_a(1'b0, 9, '0); set_b(1'b0, 3, '0); step(); idle_ports();
    @(negedge CK);
    chk("resweep_9", bus.a_rdata, '0);
    chk("resweep_3", bus.b_rdata, '0);

    chk("seen_rr", DW'(coll_seen[COLL_RR] > 0), DW'(1));
    chk("seen_wr", DW'(coll_seen[COLL_WR] > 0), DW'(1));
    chk("seen_rw", DW'(coll_seen[COLL_RW] > 0), DW'(1));
    chk("seen_ww", DW'(coll_seen[COLL_WW] > 0), DW'(1));

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lbuf_dp_ctrl.md
Name: lbuf_dp_ctrl

Overview:
Parametrised dual-port local layer buffer: the successor to the fixed 208x128 per-layer SRAM wrappers. It provides two symmetric request/ready ports with deterministic same-address collision rules, replacing the old address-LSB flipping. It also adds 1-cycle registered reads with a valid flag, out-of-range detection and a hardware zero-fill sweep. It sits between the conv/pool datapath and the per-layer storage (layer1..layerN buffers).

Parameters:
DATA_W, 128, word width in bits
DEPTH, 208, number of words
ADDR_W, $clog2(DEPTH) (=8), address width
CLEAR_ON_RESET, 1, 1 = run zero-fill sweep after reset release

Ports:
CK  in  1  clock, all logic rising-edge
RSTN  in  1  asynchronous active-low reset
clr_i  in  1  pulse: start zero-fill sweep
busy_o  out  1  high while sweep in progress
a_req  in  1  port A request
a_we  in  1  port A write (1) / read (0)
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_ready  out  1  port A accept (req && ready = accepted)
a_rvalid  out  1  port A read data valid
a_rdata  out  DATA_W  port A read data
b_req, b_we, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as port A, for port B
err_o  out  1  sticky out-of-range access flag
err_clr_i  in  1  clears err_o

Behaviour:
- Reset (RSTN=0, async): a_rvalid=b_rvalid=0; a_rdata=b_rdata=0; err_o=0; sweep counter=0. FSM goes to CLEAR if CLEAR_ON_RESET=1, else IDLE. busy_o=1 in CLEAR. Reset asserted mid-sweep restarts the sweep from address 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_i=1.
  - CLEAR writes zero to address cnt, one word per cycle, cnt 0..DEPTH-1. CLEAR -> IDLE the cycle after cnt=DEPTH-1 is written, so the sweep lasts exactly DEPTH cycles.
  - clr_i during CLEAR is ignored; it does not restart the sweep.
- Ready: a_ready=(state==IDLE). b_ready=(state==IDLE) && !(a_req && b_req && a_we && b_we && a_addr==b_addr). Ready is combinational on the current request.
- Writes: an accepted write updates storage at the rising edge. Latency 0; the data is visible to any read accepted in the next cycle.
- Reads: an accepted read gives rvalid=1 and rdata the following cycle (latency 1). When rvalid=0, rdata holds its last value.
- Same-address collisions, both ports accepted in the same cycle:
  - Both read: both receive identical stored data.
  - A write, B read: B gets a_wdata (write-first bypass).
  - A read, B write: A gets the old stored value (read-first); B's write commits.
  - Both write: A commits; B is stalled (b_ready=0). B must hold its request and is accepted next cycle, so the final value is b_wdata.
- Out-of-range (addr >= DEPTH, e.g. 208..255 for the defaults):
  - The request is accepted.
  - A write is dropped.
  - A read returns rvalid=1 with rdata=0.
  - err_o is set the next cycle.
  - err_clr_i clears err_o. If err_clr_i and a new error occur in the same cycle, the set wins.
- No request is accepted while busy_o=1. rvalid for a read accepted in the final IDLE cycle before a clr_i still returns normally.

Decomposition:
- Package lbuf_pkg holds:
  - the lbuf_state_e enum (IDLE, CLEAR);
  - the lbuf_req_t struct (req, we, addr, wdata), parametrised via localparams DATA_W_DEF=128 and DEPTH_DEF=208;
  - collision-kind constants used by the bench scoreboard.
- Sub-module lbuf_mem holds the storage array: a behavioural true dual-port array with synchronous write and registered read. It is kept separate so it can be swapped for the compiled SRAM macro.
- lbuf_dp_ctrl holds the FSM, arbitration, bypass, range check and error flag.

Test Plan:
- Reset release with CLEAR_ON_RESET=1 -> busy_o=1 for exactly 208 cycles, ready=0 throughout. Then a read of address 5 returns 0 one cycle later, with rvalid pulsing once.
- A write 0x11..11 @ addr 7, next cycle A read @7 -> a_rvalid=1, a_rdata=0x11..11 one cycle after the read.
- Same cycle: A write 0xAA..AA @3 and B read @3 -> b_rdata=0xAA..AA next cycle. Same cycle: A read @3 and B write 0x55..55 @3 -> A returns 0xAA..AA, then storage holds 0x55..55.
- Same cycle: A write 0x01 @9 and B write 0x02 @9 -> b_ready=0 in cycle 0, B accepted in cycle 1, later read @9 returns 0x02.
- B read @210 -> b_rvalid=1, b_rdata=0, err_o=1 next cycle. A write @250 leaves all words unchanged. err_clr_i pulse -> err_o=0.
- clr_i pulse, RSTN asserted at sweep cycle 100, then released -> sweep restarts from 0 and busy_o stays high for another 208 cycles. clr_i re-pulsed mid-sweep has no effect on its length.
